reg_alu_pipe: RTL and testbench

REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

---
 rtl/reg_alu_pipe_pkg.sv | 10 +
 rtl/reg_alu_pipe_reg_file_2w.sv | 35 +++
 rtl/reg_alu_pipe.sv | 75 +++++++
 tb/tb_reg_alu_pipe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_alu_pipe_pkg.sv
// reg_alu_pipe_pkg: ALU opcode encoding and ALU function shared by the reg_alu_pipe slice
package reg_alu_pipe_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} alu_op_e;
   localparam int MAX_W = 64;
   // Computed at MAX_W; callers truncate to their width, which keeps ADD/SUB modulo 2^WIDTH
   function automatic logic [MAX_W-1:0] alu_f(input alu_op_e op, input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
      return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : a | b;
   endfunction
endpackage

// File: rtl/reg_alu_pipe_reg_file_2w.sv
// reg_file_2w: 2-read/2-write write-first register file, port b wins on collision, r0 hardwired to zero
module reg_file_2w #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we_a,
   input  logic [AW-1:0]    wa_a,
   input  logic [WIDTH-1:0] wd_a,
   input  logic             we_b,
   input  logic [AW-1:0]    wa_b,
   input  logic [WIDTH-1:0] wd_b
);
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   always_comb begin
      regs_d = regs_q;
      if (we_a) regs_d[wa_a] = wd_a;
      if (we_b) regs_d[wa_b] = wd_b;
      regs_d[0] = '0;
   end
   // Reading the next-state array gives write-first behaviour on both ports
   assign rd1 = regs_d[ra1];
   assign rd2 = regs_d[ra2];
   always_ff @(posedge clk) begin
      if (rst) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end
endmodule

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: two-stage register-file ALU pipeline with valid/ready handshake and writeback bypass
module reg_alu_pipe
   import reg_alu_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WE3,
   input  logic [AW-1:0]    A3,
   input  logic [WIDTH-1:0] WD3,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    A1,
   input  logic [AW-1:0]    A2,
   input  logic [AW-1:0]    AD,
   input  logic [1:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero
);
   logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, zero_q, zero_d;
   logic             s2_free, s1_adv, accept;
   logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, res_q, res_d, rd1, rd2, alu_res;
   logic [AW-1:0]    s1_dst_q, s1_dst_d;
   alu_op_e          s1_op_q, s1_op_d;
   // Writeback on port b also serves as the S1->operand bypass through the write-first read
   reg_file_2w #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
      .clk(CLK), .rst(RST), .ra1(A1), .ra2(A2), .rd1(rd1), .rd2(rd2),
      .we_a(WE3), .wa_a(A3), .wd_a(WD3),
      .we_b(s1_adv), .wa_b(s1_dst_q), .wd_b(alu_res)
   );
   always_comb begin
      s2_free = !s2_valid_q || out_ready;
      s1_adv = s1_valid_q && s2_free;
      in_ready = !s1_valid_q || s1_adv;
      accept = in_valid && in_ready;
      alu_res = WIDTH'(alu_f(s1_op_q, MAX_W'(s1_a_q), MAX_W'(s1_b_q)));
      s1_valid_d = accept || (s1_valid_q && !s1_adv);
      s1_a_d = accept ? rd1 : s1_a_q;
      s1_b_d = accept ? rd2 : s1_b_q;
      s1_op_d = accept ? alu_op_e'(ALUOp) : s1_op_q;
      s1_dst_d = accept ? AD : s1_dst_q;
      s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
      res_d = s1_adv ? alu_res : res_q;
      zero_d = s1_adv ? alu_res == '0 : zero_q;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_a_q <= '0;
         s1_b_q <= '0;
         s1_op_q <= OP_ADD;
         s1_dst_q <= '0;
         s2_valid_q <= 1'b0;
         res_q <= '0;
         zero_q <= 1'b1;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q <= s1_a_d;
         s1_b_q <= s1_b_d;
         s1_op_q <= s1_op_d;
         s1_dst_q <= s1_dst_d;
         s2_valid_q <= s2_valid_d;
         res_q <= res_d;
         zero_q <= zero_d;
      end
   end
   assign out_valid = s2_valid_q;
   assign ALUResult = res_q;
   assign Zero = zero_q;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_reg_alu_pipe;
   logic        CLK = 1'b0, RST = 1'b1, WE3 = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [4:0]  A3 = '0, A1 = '0, A2 = '0, AD = '0;
   logic [31:0] WD3 = '0;
   logic [1:0]  ALUOp = '0;
   logic        in_ready, out_valid, Zero;
   logic [31:0] ALUResult;
   int          checks = 0, fails = 0, w;
   logic [31:0] exp_q[$];
   logic [31:0] held_r;
   bit          held_v = 0;

   reg_alu_pipe dut (
      .CLK(CLK), .RST(RST), .WE3(WE3), .A3(A3), .WD3(WD3),
      .in_valid(in_valid), .in_ready(in_ready), .A1(A1), .A2(A2), .AD(AD), .ALUOp(ALUOp),
      .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask

   always @(negedge CLK) begin
      logic [31:0] e;
      if (!RST && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_output got=%h expected=none", ALUResult);
         end else begin
            e = exp_q.pop_front();
            chk("result", ALUResult, e);
            chk("zero", 32'(Zero), 32'(e == '0));
         end
      end
      if (!RST && out_valid && !out_ready) begin
         if (held_v) chk("stall_stable", ALUResult, held_r);
         held_v = 1;
         held_r = ALUResult;
      end else held_v = 0;
   end

   task automatic issue(input int op, input int a1, input int a2, input int ad,
                        input logic [31:0] exp, input bit push, output int waits);
      in_valid = 1'b1;
      ALUOp = 2'(op);
      A1 = 5'(a1);
      A2 = 5'(a2);
      AD = 5'(ad);
      waits = 0;
      @(negedge CLK);
      while (!in_ready && waits < 50) begin
         @(negedge CLK);
         waits++;
      end
      if (!in_ready) begin
         checks++;
         fails++;
         $display("FAIL issue_timeout in_ready=0 expected=1");
      end else if (push) exp_q.push_back(exp);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic op(input int o, input int a1, input int a2, input int ad, input logic [31:0] exp);
      int x;
      issue(o, a1, a2, ad, exp, 1'b1, x);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      WE3 = 1'b1;
      A3 = 5'(a);
      WD3 = d;
      @(posedge CLK);
      #1;
      WE3 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", ALUResult, 32'd0);
      chk("rst_zero", 32'(Zero), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      idle(1);
      wr(1, 5);
      wr(2, 3);
      op(0, 1, 2, 3, 8);
      @(negedge CLK);
      chk("latency_s1", 32'(out_valid), 32'd0);
      @(negedge CLK);
      chk("latency_s2", 32'(out_valid), 32'd1);
      idle(1);
      op(0, 3, 0, 7, 8);
      op(1, 2, 2, 4, 0);
      op(1, 2, 1, 8, 32'hFFFF_FFFE);
      idle(3);
      op(0, 1, 2, 23, 8);
      issue(0, 23, 1, 5, 13, 1'b1, w);
      chk("b2b_waits", 32'(w), 32'd0);
      op(2, 1, 2, 9, 1);
      op(3, 1, 2, 10, 7);
      idle(3);
      out_ready = 1'b0;
      op(0, 1, 1, 11, 10);
      op(1, 1, 2, 12, 2);
      in_valid = 1'b1;
      ALUOp = 2'd3;
      A1 = 5'd5;
      A2 = 5'd2;
      AD = 5'd13;
      repeat (3) begin
         @(negedge CLK);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge CLK);
      #1;
      out_ready = 1'b1;
      op(3, 5, 2, 13, 15);
      idle(3);
      op(1, 11, 9, 6, 9);
      wr(6, 7);
      op(0, 6, 0, 14, 9);
      op(0, 1, 0, 15, 5);
      wr(16, 21);
      op(0, 15, 16, 24, 26);
      WE3 = 1'b1;
      A3 = 5'd17;
      WD3 = 32'd4;
      op(0, 17, 0, 18, 4);
      WE3 = 1'b0;
      op(0, 1, 2, 0, 8);
      wr(0, 99);
      op(0, 0, 0, 19, 0);
      op(0, 0, 1, 27, 5);
      idle(4);
      out_ready = 1'b0;
      issue(0, 0, 0, 0, 0, 1'b0, w);
      issue(0, 1, 1, 20, 10, 1'b0, w);
      RST = 1'b1;
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_result", ALUResult, 32'd0);
      chk("rst2_in_ready", 32'(in_ready), 32'd1);
      op(0, 20, 0, 25, 0);
      op(0, 1, 2, 26, 0);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
      idle(1);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
